seq_detect_1011: RTL and testbench
==================================

Name: seq_detect_1011

Overview:
- Serial-bit pattern detector that sits directly downstream of the team's single-bit FSM generators (toggle/pattern sources) and consumes their 1-bit output stream.
- Detects the sequence 1011, MSB first, on sampled bits.
- Emits a registered match pulse and keeps a saturating match count.
- Aborts a partial match after a configurable idle gap on the input.

Parameters:
- OVERLAP, 1, 1 = overlapping detection (after a match, the trailing "1" is reused as a prefix); 0 = restart from idle after each match.
- CNT_W, 8, width of the match counter.
- TIMEOUT, 16, idle-cycle limit while a partial match is held; 0 disables the timeout. Legal range is 0 to 2^16-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- din  input  1  serial data bit, valid only when din_valid=1
- din_valid  input  1  sample strobe; din is consumed on each clk edge where din_valid=1
- clr_cnt  input  1  synchronous clear of match_cnt
- match  output  1  one-cycle pulse, the cycle after the sample that completes 1011
- match_cnt  output  CNT_W  saturating count of matches
- timeout  output  1  one-cycle pulse when a partial match is abandoned
- state_o  output  2  current FSM state encoding, for debug

Behaviour:
- Reset (rst=1, asynchronous, takes effect immediately):
  - state = S0, match = 0, match_cnt = 0, timeout = 0, idle counter = 0.
  - Reset mid-sequence discards the partial match with no timeout pulse.
- States and encoding: S0=0 (idle), S1=1 ("1"), S10=2 ("10"), S101=3 ("101").
- Transitions occur only on edges with din_valid=1:
  - S0: din=1 -> S1; din=0 -> S0
  - S1: din=0 -> S10; din=1 -> S1
  - S10: din=1 -> S101; din=0 -> S0
  - S101: din=1 -> match; next state is S1 if OVERLAP=1, S0 if OVERLAP=0
  - S101: din=0 -> S10 (the suffix "10" is retained)
- When din_valid=0, state holds.
- match:
  - Registered output, driven high for exactly one cycle on the edge that accepts the completing bit, so it is visible the following cycle.
  - Latency from the final sample to match is 1 clk.
  - Back-to-back matches need at least 3 further valid samples (OVERLAP=1) or 4 (OVERLAP=0).
- match_cnt:
  - +1 on each match.
  - Saturates at 2^CNT_W-1 and never wraps.
  - clr_cnt=1 sets it to 0 on the next edge. If clr_cnt and a match occur on the same edge, clear wins: count = 0, but match still pulses.
- Idle counter (16 bit):
  - Increments on each edge where din_valid=0 and state != S0.
  - Resets to 0 on any valid sample or while in S0.
- Timeout:
  - When the idle counter reaches TIMEOUT (TIMEOUT>0), on that edge state -> S0, the idle counter -> 0, and timeout pulses for 1 cycle.
  - If a valid sample arrives on the edge where the limit would be reached, the sample wins and no timeout occurs.
- Outputs are glitch-free registers. state_o is a direct copy of the state register.

Decomposition:
- Shared package seq_pkg holds:
  - the state typedef (S0, S1, S10, S101, 2-bit)
  - the constant PATTERN = 4'b1011
  - the default CNT_W
- One natural sub-module: sat_counter (generic width, inc/clr inputs, saturating), reused for match_cnt.
- The idle counter stays inline.

Test Plan:
- Reset then din stream 1,0,1,1 with din_valid=1 every cycle -> match=1 one cycle after the 4th bit; match_cnt=1; state_o=1 (OVERLAP=1).
- OVERLAP=1, stream 1,0,1,1,0,1,1 -> two match pulses, 3 cycles apart; match_cnt=2. The same stream with OVERLAP=0 -> one match; match_cnt=1.
- Alternating toggle stream 1,0,1,0,... for 20 cycles -> no match; state oscillates between S10 and S101; match_cnt=0.
- Timeout, TIMEOUT=16: send 1,0,1, then hold din_valid=0 for 16 cycles -> timeout pulse on the 16th idle edge; state_o=0. Then send 1 -> state_o=1 and no match.
- Saturation and clear, CNT_W=2:
  - 5 matches -> match_cnt stays 3.
  - Assert clr_cnt on the edge of a 6th match -> match pulses and match_cnt=0.
- Async reset asserted mid-clock while in S101 -> all outputs 0 immediately, with no match or timeout pulse afterward.

Source files
------------

// File: rtl/seq_pkg.sv
// ----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the 1011 serial pattern detector:
//   - state_t      : 2-bit FSM state (S0 idle, S1 "1", S10 "10", S101 "101")
//   - PATTERN      : the detected bit sequence, MSB received first
//   - CNT_W_DEF    : default width of the match counter
//   - IDLE_W       : width of the idle-gap counter
//   - next_state() : FSM transition function
//   - is_match()   : completion test for the pattern
// ----------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic [1:0] {
    S0   = 2'd0,
    S1   = 2'd1,
    S10  = 2'd2,
    S101 = 2'd3
  } state_t;

  localparam logic [3:0] PATTERN   = 4'b1011;
  localparam int         CNT_W_DEF = 8;
  localparam int         IDLE_W    = 16;

  // Each state waits for PATTERN bit (3 - state). On a miss the FSM falls back
  // to the longest proper suffix of the received bits that is still a prefix.
  function automatic state_t next_state(input state_t s, input logic b, input logic overlap);
    state_t n;
    case (s)
      S0:      n = (b == PATTERN[3]) ? S1   : S0;
      S1:      n = (b == PATTERN[2]) ? S10  : S1;    // "11" keeps the trailing "1"
      S10:     n = (b == PATTERN[1]) ? S101 : S0;    // "100" shares nothing
      S101:    n = (b == PATTERN[0]) ? (overlap ? S1 : S0)
                                     : S10;          // "1010" keeps "10"
      default: n = S0;
    endcase
    return n;
  endfunction

  function automatic logic is_match(input state_t s, input logic b);
    return (s == S101) && (b == PATTERN[0]);
  endfunction

endpackage

// File: rtl/seq_detect_1011_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Generic saturating up-counter with synchronous clear.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset (count -> 0)
//   inc_i  : add one on this edge unless already at all-ones
//   clr_i  : force the count to zero on this edge; has priority over inc_i
//   cnt_o  : registered count
// ----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear first, then saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_VAL)) begin
      cnt_d = cnt_q + W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detect_1011.sv
// ----------------------------------------------------------------------------
// seq_detect_1011
// Serial detector for the bit sequence 1011 (MSB first) on a strobed 1-bit
// stream, with a saturating match count and an idle-gap abort.
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   din        : serial data bit, consumed when din_valid=1
//   din_valid  : sample strobe
//   clr_cnt    : synchronous clear of match_cnt (wins over a same-edge match)
//   match      : one-cycle pulse the cycle after the completing sample
//   match_cnt  : saturating count of matches
//   timeout    : one-cycle pulse when a held partial match is abandoned
//   state_o    : current FSM state, for debug
// Parameters:
//   OVERLAP : 1 = reuse the trailing "1" after a match, 0 = restart at idle
//   CNT_W   : width of match_cnt
//   TIMEOUT : idle edges tolerated in a partial match (0 disables the abort)
// ----------------------------------------------------------------------------
module seq_detect_1011
  import seq_pkg::*;
#(
  parameter int OVERLAP = 1,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_cnt,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             timeout,
  output logic [1:0]       state_o
);

  localparam logic              OVL_EN  = (OVERLAP != 0);
  localparam logic              TO_EN   = (TIMEOUT != 0);
  localparam logic [IDLE_W-1:0] TO_LIM  = IDLE_W'(TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_MX = {IDLE_W{1'b1}};

  state_t            state_q,   state_d;
  logic [IDLE_W-1:0] idle_q,    idle_d;
  logic              match_q,   match_d;
  logic              timeout_q, timeout_d;

  // FSM next state, idle-gap tracking and the two output pulses.
  always_comb begin
    state_d   = state_q;
    idle_d    = '0;
    match_d   = 1'b0;
    timeout_d = 1'b0;
    if (din_valid) begin
      // A valid sample always wins over an expiring idle gap.
      state_d = next_state(state_q, din, OVL_EN);
      match_d = is_match(state_q, din);
    end else if (state_q != S0) begin
      if (TO_EN && ((idle_q + IDLE_W'(1'b1)) == TO_LIM)) begin
        state_d   = S0;
        timeout_d = 1'b1;
      end else if (idle_q != IDLE_MX) begin
        idle_d = idle_q + IDLE_W'(1'b1);
      end else begin
        // Only reachable with the abort disabled: hold instead of wrapping.
        idle_d = idle_q;
      end
    end else begin
      idle_d = '0;
    end
  end

  // State, idle counter and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S0;
      idle_q    <= '0;
      match_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idle_q    <= idle_d;
      match_q   <= match_d;
      timeout_q <= timeout_d;
    end
  end

  // The count advances on the same edge that registers the match pulse.
  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (match_d),
    .clr_i (clr_cnt),
    .cnt_o (match_cnt)
  );

  assign match   = match_q;
  assign timeout = timeout_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_seq_detect_1011.sv
// ----------------------------------------------------------------------------
// tb_seq_detect_1011
// Three detector instances share one stimulus stream:
//   dut 0 : OVERLAP=1, CNT_W=8, TIMEOUT=16
//   dut 1 : OVERLAP=0, CNT_W=8, TIMEOUT=16
//   dut 2 : OVERLAP=1, CNT_W=2, TIMEOUT=0
// Stimulus pushes hand-computed expectations into a queue; a monitor pops
// and compares them shortly after each rising edge.
// ----------------------------------------------------------------------------
module tb_seq_detect_1011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic clr_cnt = 1'b0;

  logic       m_a, m_b, m_c;
  logic       to_a, to_b, to_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic [1:0] st_a, st_b, st_c;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         dut;
    logic [1:0] st;
    logic       m;
    logic [7:0] cnt;
    logic       to;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  seq_detect_1011 #(.OVERLAP(1), .CNT_W(8), .TIMEOUT(16)) dut_a (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
    .match(m_a), .match_cnt(cnt_a), .timeout(to_a), .state_o(st_a));

  seq_detect_1011 #(.OVERLAP(0), .CNT_W(8), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
    .match(m_b), .match_cnt(cnt_b), .timeout(to_b), .state_o(st_b));

  seq_detect_1011 #(.OVERLAP(1), .CNT_W(2), .TIMEOUT(0)) dut_c (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
    .match(m_c), .match_cnt(cnt_c), .timeout(to_c), .state_o(st_c));

  task automatic chk(input string name, input int dut, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t: got %0d, expected %0d", name, dut, $time, act, exp);
    end
  endtask

  task automatic check_dut(input int d, input logic [1:0] st, input logic m,
                           input logic [7:0] cnt, input logic to);
    logic [1:0] a_st;
    logic       a_m;
    logic [7:0] a_cnt;
    logic       a_to;
    case (d)
      0:       begin a_st = st_a; a_m = m_a; a_cnt = cnt_a;         a_to = to_a; end
      1:       begin a_st = st_b; a_m = m_b; a_cnt = cnt_b;         a_to = to_b; end
      default: begin a_st = st_c; a_m = m_c; a_cnt = {6'd0, cnt_c}; a_to = to_c; end
    endcase
    chk("state_o",   d, {6'd0, a_st}, {6'd0, st});
    chk("match",     d, {7'd0, a_m},  {7'd0, m});
    chk("match_cnt", d, a_cnt,        cnt);
    chk("timeout",   d, {7'd0, a_to}, {7'd0, to});
  endtask

  // Drive one sample between rising edges.
  task automatic step(input logic v, input logic d, input logic c);
    @(negedge clk);
    din_valid = v;
    din       = d;
    clr_cnt   = c;
  endtask

  // Expected outputs of one instance after the coming rising edge.
  task automatic ex(input int dut, input logic [1:0] st, input logic m,
                    input logic [7:0] cnt, input logic to);
    exp_t e;
    e.dut = dut; e.st = st; e.m = m; e.cnt = cnt; e.to = to;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; din_valid = 1'b0; din = 1'b0; clr_cnt = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) check_dut(d, 2'd0, 1'b0, 8'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: compare every queued expectation just after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check_dut(e.dut, e.st, e.m, e.cnt, e.to);
      end
    end
  end

  // Hard bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c;

    // --- 1011 and 1011011 on both overlap settings ---
    do_reset();
    step(1'b1, 1'b1, 1'b0); ex(0, 2'd1, 1'b0, 8'd0, 1'b0); ex(1, 2'd1, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0); ex(0, 2'd2, 1'b0, 8'd0, 1'b0); ex(1, 2'd2, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0); ex(0, 2'd3, 1'b0, 8'd0, 1'b0); ex(1, 2'd3, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0); ex(0, 2'd1, 1'b1, 8'd1, 1'b0); ex(1, 2'd0, 1'b1, 8'd1, 1'b0);
    step(1'b1, 1'b0, 1'b0); ex(0, 2'd2, 1'b0, 8'd1, 1'b0); ex(1, 2'd0, 1'b0, 8'd1, 1'b0);
    step(1'b1, 1'b1, 1'b0); ex(0, 2'd3, 1'b0, 8'd1, 1'b0); ex(1, 2'd1, 1'b0, 8'd1, 1'b0);
    step(1'b1, 1'b1, 1'b0); ex(0, 2'd1, 1'b1, 8'd2, 1'b0); ex(1, 2'd1, 1'b0, 8'd1, 1'b0);

    // --- alternating toggle stream: S10/S101 oscillation, never a match ---
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, (i % 2 == 0), 1'b0);
      if (i == 0)          ex(0, 2'd1, 1'b0, 8'd0, 1'b0);
      else if (i % 2 == 1) ex(0, 2'd2, 1'b0, 8'd0, 1'b0);
      else                 ex(0, 2'd3, 1'b0, 8'd0, 1'b0);
    end

    // --- sample on the limit edge beats the timeout, then a real timeout ---
    do_reset();
    step(1'b1, 1'b1, 1'b0); ex(0, 2'd1, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0); ex(0, 2'd2, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0); ex(0, 2'd3, 1'b0, 8'd0, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      step(1'b0, 1'b0, 1'b0); ex(0, 2'd3, 1'b0, 8'd0, 1'b0);
    end
    step(1'b1, 1'b1, 1'b0); ex(0, 2'd1, 1'b1, 8'd1, 1'b0);
    step(1'b1, 1'b0, 1'b0); ex(0, 2'd2, 1'b0, 8'd1, 1'b0);
    step(1'b1, 1'b1, 1'b0); ex(0, 2'd3, 1'b0, 8'd1, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      step(1'b0, 1'b0, 1'b0); ex(0, 2'd3, 1'b0, 8'd1, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0); ex(0, 2'd0, 1'b0, 8'd1, 1'b1);
    step(1'b0, 1'b0, 1'b0); ex(0, 2'd0, 1'b0, 8'd1, 1'b0);
    step(1'b1, 1'b1, 1'b0); ex(0, 2'd1, 1'b0, 8'd1, 1'b0);

    // --- CNT_W=2 saturation, clear beating a match, timeout disabled ---
    do_reset();
    step(1'b1, 1'b1, 1'b0); ex(2, 2'd1, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0); ex(2, 2'd2, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0); ex(2, 2'd3, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0); ex(2, 2'd1, 1'b1, 8'd1, 1'b0);
    c = 8'd1;
    for (int k = 2; k <= 5; k++) begin
      step(1'b1, 1'b0, 1'b0); ex(2, 2'd2, 1'b0, c, 1'b0);
      step(1'b1, 1'b1, 1'b0); ex(2, 2'd3, 1'b0, c, 1'b0);
      if (c < 8'd3) c = c + 8'd1;
      step(1'b1, 1'b1, 1'b0); ex(2, 2'd1, 1'b1, c, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0); ex(2, 2'd2, 1'b0, 8'd3, 1'b0);
    step(1'b1, 1'b1, 1'b0); ex(2, 2'd3, 1'b0, 8'd3, 1'b0);
    step(1'b1, 1'b1, 1'b1); ex(2, 2'd1, 1'b1, 8'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0); ex(2, 2'd2, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0); ex(2, 2'd3, 1'b0, 8'd0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b0, 1'b0); ex(2, 2'd3, 1'b0, 8'd0, 1'b0);
    end
    step(1'b1, 1'b1, 1'b0); ex(2, 2'd1, 1'b1, 8'd1, 1'b0);

    // --- async reset in S101 with a completing bit already presented ---
    do_reset();
    step(1'b1, 1'b1, 1'b0); ex(0, 2'd1, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0); ex(0, 2'd2, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0); ex(0, 2'd3, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0); ex(0, 2'd1, 1'b1, 8'd1, 1'b0);
    step(1'b1, 1'b0, 1'b0); ex(0, 2'd2, 1'b0, 8'd1, 1'b0);
    step(1'b1, 1'b1, 1'b0); ex(0, 2'd3, 1'b0, 8'd1, 1'b0);
    @(negedge clk);
    din_valid = 1'b1; din = 1'b1;
    #2 rst = 1'b1;
    #1 check_dut(0, 2'd0, 1'b0, 8'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0; din_valid = 1'b0; din = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0); ex(0, 2'd0, 1'b0, 8'd0, 1'b0);
    end

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 0, 8'(exp_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
